// File: rtl/qpsk_mapper.sv
// QPSK symbol mapper: per frame, emits an alternating 00/11 preamble, then
// Gray-maps each payload byte (MSB dibit first) into signed 12-bit I/Q.
// The output register uses a valid/ready handshake with the downstream stage.
module qpsk_mapper #(
  parameter int AMP          = 1448,
  parameter int PREAMBLE_LEN = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  i_data,
  input  logic        i_valid,
  input  logic        i_last,
  output logic        o_ready,
  output logic [11:0] o_I,
  output logic [11:0] o_Q,
  output logic        o_valid,
  input  logic        i_out_ready,
  output logic        o_busy
);

  localparam int unsigned SAMP_W = 12;
  localparam int unsigned CNT_W  = 8;

  localparam logic [SAMP_W-1:0] POS      = SAMP_W'(AMP);
  localparam logic [SAMP_W-1:0] NEG      = SAMP_W'(-AMP);
  localparam logic [CNT_W-1:0]  PRE_LAST = CNT_W'(PREAMBLE_LEN - 1);

  typedef enum logic [1:0] {IDLE, PREAMBLE, DATA} state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  pre_cnt, pre_cnt_nxt;
  logic [7:0]        byte_reg, byte_nxt;
  logic              byte_full, full_nxt;
  logic [1:0]        idx, idx_nxt;
  logic              last_reg, last_nxt;
  logic              valid_nxt;
  logic [SAMP_W-1:0] i_nxt, q_nxt;
  logic              ready_c;
  logic              advance;
  logic              sym_avail;
  logic [1:0]        sym_dibit;
  logic [1:0]        cur_dibit;

  // Output register may take a new symbol when it is empty or being drained
  assign advance = !o_valid || i_out_ready;
  assign o_ready = ready_c;

  // Dibit of the held byte selected by the index, MSB pair first
  always_comb begin
    cur_dibit = byte_reg[7:6];
    case (idx)
      2'd0: cur_dibit = byte_reg[7:6];
      2'd1: cur_dibit = byte_reg[5:4];
      2'd2: cur_dibit = byte_reg[3:2];
      2'd3: cur_dibit = byte_reg[1:0];
      default: cur_dibit = byte_reg[7:6];
    endcase
  end

  // Next-state, byte/preamble bookkeeping and output-register load
  always_comb begin
    state_nxt   = state;
    pre_cnt_nxt = pre_cnt;
    byte_nxt    = byte_reg;
    full_nxt    = byte_full;
    idx_nxt     = idx;
    last_nxt    = last_reg;
    valid_nxt   = o_valid;
    i_nxt       = o_I;
    q_nxt       = o_Q;
    ready_c     = 1'b0;
    sym_avail   = 1'b0;
    sym_dibit   = 2'b00;

    case (state)
      IDLE: begin
        if (i_valid) state_nxt = PREAMBLE;
      end

      PREAMBLE: begin
        sym_avail = 1'b1;
        sym_dibit = pre_cnt[0] ? 2'b11 : 2'b00;
        if (advance) begin
          if (pre_cnt == PRE_LAST) begin
            pre_cnt_nxt = '0;
            state_nxt   = DATA;
          end else begin
            pre_cnt_nxt = pre_cnt + CNT_W'(1);
          end
        end
      end

      DATA: begin
        if (byte_full) begin
          sym_avail = 1'b1;
          sym_dibit = cur_dibit;
          if (advance) begin
            idx_nxt = idx + 2'd1;
            if (idx == 2'd3) begin
              if (last_reg) begin
                full_nxt  = 1'b0;
                state_nxt = IDLE;
              end else begin
                // Refill in the same cycle so byte boundaries add no bubble
                ready_c = 1'b1;
                if (i_valid) begin
                  byte_nxt = i_data;
                  last_nxt = i_last;
                  full_nxt = 1'b1;
                end else begin
                  full_nxt = 1'b0;
                end
              end
            end
          end
        end else begin
          ready_c = 1'b1;
          if (i_valid) begin
            byte_nxt = i_data;
            last_nxt = i_last;
            full_nxt = 1'b1;
            // First dibit goes straight to the output when it has room
            if (advance) begin
              sym_avail = 1'b1;
              sym_dibit = i_data[7:6];
              idx_nxt   = 2'd1;
            end else begin
              idx_nxt   = 2'd0;
            end
          end
        end
      end

      default: state_nxt = IDLE;
    endcase

    if (advance) begin
      valid_nxt = sym_avail;
      if (sym_avail) begin
        i_nxt = sym_dibit[1] ? NEG : POS;
        q_nxt = sym_dibit[0] ? NEG : POS;
      end
    end
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      pre_cnt   <= '0;
      byte_reg  <= '0;
      byte_full <= 1'b0;
      idx       <= '0;
      last_reg  <= 1'b0;
      o_valid   <= 1'b0;
      o_I       <= '0;
      o_Q       <= '0;
      o_busy    <= 1'b0;
    end else begin
      state     <= state_nxt;
      pre_cnt   <= pre_cnt_nxt;
      byte_reg  <= byte_nxt;
      byte_full <= full_nxt;
      idx       <= idx_nxt;
      last_reg  <= last_nxt;
      o_valid   <= valid_nxt;
      o_I       <= i_nxt;
      o_Q       <= q_nxt;
      o_busy    <= (state_nxt != IDLE);
    end
  end

endmodule

// File: tb/tb_qpsk_mapper.sv
// Directed bench for qpsk_mapper with PREAMBLE_LEN=4, AMP=1448.
module tb_qpsk_mapper;

  localparam logic [11:0] P = 12'h5A8;
  localparam logic [11:0] N = 12'hA58;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  i_data = '0;
  logic        i_valid = 1'b0;
  logic        i_last = 1'b0;
  logic        o_ready;
  logic [11:0] o_I, o_Q;
  logic        o_valid;
  logic        i_out_ready = 1'b1;
  logic        o_busy;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int rdy_mode = 0;
  bit force_low = 1'b0;

  logic [23:0] got_q[$];
  int          got_cyc[$];
  logic [23:0] exp_q[$];

  qpsk_mapper #(.AMP(1448), .PREAMBLE_LEN(4)) dut (
    .clk(clk), .rst(rst), .i_data(i_data), .i_valid(i_valid), .i_last(i_last),
    .o_ready(o_ready), .o_I(o_I), .o_Q(o_Q), .o_valid(o_valid),
    .i_out_ready(i_out_ready), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Downstream ready pattern
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      1:       i_out_ready = ((cyc % 8) == 0);
      default: i_out_ready = !force_low;
    endcase
  end

  // Record every transferred symbol and its cycle
  always @(negedge clk) begin
    if (!rst && o_valid && i_out_ready) begin
      got_q.push_back({o_I, o_Q});
      got_cyc.push_back(cyc);
    end
  end

  function automatic logic [23:0] sym(input logic [1:0] d);
    case (d)
      2'b00:   return {P, P};
      2'b01:   return {P, N};
      2'b10:   return {N, P};
      default: return {N, N};
    endcase
  endfunction

  task automatic add_preamble();
    exp_q.push_back({P, P}); exp_q.push_back({N, N});
    exp_q.push_back({P, P}); exp_q.push_back({N, N});
  endtask

  task automatic add_byte(input logic [7:0] b);
    logic [7:0] v;
    v = b;
    exp_q.push_back(sym(v[7:6])); exp_q.push_back(sym(v[5:4]));
    exp_q.push_back(sym(v[3:2])); exp_q.push_back(sym(v[1:0]));
  endtask

  task automatic clear_q();
    got_q.delete(); got_cyc.delete(); exp_q.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1; i_valid = 1'b0; i_data = '0; i_last = 1'b0;
    rdy_mode = 0; force_low = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    clear_q();
  endtask

  // Present a byte and hold it until the DUT accepts it (bounded)
  task automatic send_byte(input logic [7:0] d, input logic l, output bit ok);
    bit acc;
    ok = 1'b0;
    i_data = d; i_last = l; i_valid = 1'b1;
    for (int t = 0; t < 400; t++) begin
      @(negedge clk);
      acc = o_ready;
      @(posedge clk);
      #1;
      if (acc) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_syms(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int t = 0; t < budget; t++) begin
      if (got_q.size() >= n) begin ok = 1'b1; break; end
      @(posedge clk);
      #2;
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", o_valid); end
    checks++; if (o_I !== 12'h000) begin errors++; $display("FAIL reset_I: got %h want 000", o_I); end
    checks++; if (o_Q !== 12'h000) begin errors++; $display("FAIL reset_Q: got %h want 000", o_Q); end
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", o_busy); end
    checks++; if (o_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", o_ready); end
  endtask

  task automatic test_single_frame();
    bit ok, ok2;
    clear_q(); add_preamble(); add_byte(8'h1B);
    @(posedge clk); #1;
    fork
      begin send_byte(8'h1B, 1'b1, ok); i_valid = 1'b0; end
      begin
        @(posedge clk); #2;
        checks++; if (o_valid !== 1'b0 || o_busy !== 1'b1) begin errors++; $display("FAIL latency_n1: valid=%b busy=%b want 0/1", o_valid, o_busy); end
        @(posedge clk); #2;
        checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL latency_n2: valid=%b want 1", o_valid); end
        checks++; if ({o_I, o_Q} !== {P, P}) begin errors++; $display("FAIL latency_sym: got %h want %h", {o_I, o_Q}, {P, P}); end
      end
    join
    checks++; if (!ok) begin errors++; $display("FAIL single_accept: byte not accepted"); end
    wait_syms(8, 200, ok2);
    repeat (5) @(posedge clk);
    #2;
    checks++; if (got_q.size() != 8) begin errors++; $display("FAIL single_count: got %0d want 8", got_q.size()); end
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (k >= got_q.size() || got_q[k] !== exp_q[k]) begin
        errors++; $display("FAIL single_seq[%0d]: got %h want %h", k, (k < got_q.size()) ? got_q[k] : 24'hx, exp_q[k]);
      end
    end
    checks++; if (o_valid !== 1'b0 || o_busy !== 1'b0) begin errors++; $display("FAIL single_end: valid=%b busy=%b want 0/0", o_valid, o_busy); end
  endtask

  task automatic test_back_to_back();
    bit ok1, ok2, ok3;
    clear_q(); add_preamble(); add_byte(8'hFF); add_byte(8'h00);
    send_byte(8'hFF, 1'b0, ok1);
    send_byte(8'h00, 1'b1, ok2);
    i_valid = 1'b0;
    checks++; if (!(ok1 && ok2)) begin errors++; $display("FAIL b2b_accept: ok1=%b ok2=%b", ok1, ok2); end
    wait_syms(12, 200, ok3);
    repeat (5) @(posedge clk);
    #2;
    checks++; if (got_q.size() != 12) begin errors++; $display("FAIL b2b_count: got %0d want 12", got_q.size()); end
    for (int k = 0; k < 12; k++) begin
      checks++;
      if (k >= got_q.size() || got_q[k] !== exp_q[k]) begin
        errors++; $display("FAIL b2b_seq[%0d]: got %h want %h", k, (k < got_q.size()) ? got_q[k] : 24'hx, exp_q[k]);
      end
    end
    for (int k = 0; k < 11; k++) begin
      checks++;
      if (k + 1 >= got_cyc.size() || got_cyc[k+1] - got_cyc[k] != 1) begin
        errors++; $display("FAIL b2b_gap[%0d]: symbol spacing not 1 cycle", k);
      end
    end
  endtask

  task automatic test_stall();
    bit ok, ok2;
    logic [11:0] si, sq;
    clear_q(); add_preamble(); add_byte(8'h1B);
    fork
      begin send_byte(8'h1B, 1'b1, ok); i_valid = 1'b0; end
      begin
        for (int t = 0; t < 50; t++) begin @(negedge clk); if (o_valid) break; end
        force_low = 1'b1;
        @(posedge clk); #2;
        @(negedge clk);
        si = o_I; sq = o_Q;
        for (int c = 0; c < 5; c++) begin
          @(negedge clk);
          checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL stall_valid[%0d]: got %b want 1", c, o_valid); end
          checks++; if (o_I !== si) begin errors++; $display("FAIL stall_I[%0d]: got %h want %h", c, o_I, si); end
          checks++; if (o_Q !== sq) begin errors++; $display("FAIL stall_Q[%0d]: got %h want %h", c, o_Q, sq); end
        end
        force_low = 1'b0;
      end
    join
    wait_syms(8, 200, ok2);
    repeat (5) @(posedge clk);
    #2;
    checks++; if (got_q.size() != 8) begin errors++; $display("FAIL stall_count: got %0d want 8", got_q.size()); end
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (k >= got_q.size() || got_q[k] !== exp_q[k]) begin
        errors++; $display("FAIL stall_seq[%0d]: got %h want %h", k, (k < got_q.size()) ? got_q[k] : 24'hx, exp_q[k]);
      end
    end
  endtask

  task automatic test_hold_pattern();
    bit ok, ok2;
    clear_q(); add_preamble(); add_byte(8'h1B);
    rdy_mode = 1;
    send_byte(8'h1B, 1'b1, ok);
    i_valid = 1'b0;
    checks++; if (!ok) begin errors++; $display("FAIL hold_accept: byte not accepted"); end
    wait_syms(8, 300, ok2);
    repeat (20) @(posedge clk);
    #2;
    checks++; if (got_q.size() != 8) begin errors++; $display("FAIL hold_count: got %0d want 8", got_q.size()); end
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (k >= got_q.size() || got_q[k] !== exp_q[k]) begin
        errors++; $display("FAIL hold_seq[%0d]: got %h want %h", k, (k < got_q.size()) ? got_q[k] : 24'hx, exp_q[k]);
      end
    end
    for (int k = 0; k < 7; k++) begin
      checks++;
      if (k + 1 >= got_cyc.size() || got_cyc[k+1] - got_cyc[k] != 8) begin
        errors++; $display("FAIL hold_gap[%0d]: symbol spacing not 8 cycles", k);
      end
    end
    rdy_mode = 0;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_reset_mid_frame();
    bit ok, ok2, ok3;
    clear_q();
    send_byte(8'h1B, 1'b1, ok);
    i_valid = 1'b0;
    wait_syms(5, 100, ok2);
    checks++; if ({o_I, o_Q} !== {P, N} || o_valid !== 1'b1) begin errors++; $display("FAIL midrst_pre: got %h valid=%b want %h valid=1", {o_I, o_Q}, o_valid, {P, N}); end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %b want 0", o_valid); end
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b want 0", o_busy); end
    clear_q(); add_preamble(); add_byte(8'h1B);
    send_byte(8'h1B, 1'b1, ok);
    i_valid = 1'b0;
    wait_syms(8, 200, ok3);
    repeat (5) @(posedge clk);
    #2;
    checks++; if (got_q.size() != 8) begin errors++; $display("FAIL midrst_count: got %0d want 8", got_q.size()); end
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (k >= got_q.size() || got_q[k] !== exp_q[k]) begin
        errors++; $display("FAIL midrst_seq[%0d]: got %h want %h", k, (k < got_q.size()) ? got_q[k] : 24'hx, exp_q[k]);
      end
    end
  endtask

  task automatic test_last_blocks();
    bit ok1, ok2, ok3;
    clear_q(); add_preamble(); add_byte(8'h1B); add_preamble(); add_byte(8'hE4);
    send_byte(8'h1B, 1'b1, ok1);
    i_data = 8'hE4; i_last = 1'b1; i_valid = 1'b1;
    @(negedge clk);
    checks++; if (o_ready !== 1'b0) begin errors++; $display("FAIL last_ready: got %b want 0", o_ready); end
    send_byte(8'hE4, 1'b1, ok2);
    i_valid = 1'b0;
    checks++; if (!(ok1 && ok2)) begin errors++; $display("FAIL last_accept: ok1=%b ok2=%b", ok1, ok2); end
    wait_syms(16, 300, ok3);
    repeat (5) @(posedge clk);
    #2;
    checks++; if (got_q.size() != 16) begin errors++; $display("FAIL last_count: got %0d want 16", got_q.size()); end
    for (int k = 0; k < 16; k++) begin
      checks++;
      if (k >= got_q.size() || got_q[k] !== exp_q[k]) begin
        errors++; $display("FAIL last_seq[%0d]: got %h want %h", k, (k < got_q.size()) ? got_q[k] : 24'hx, exp_q[k]);
      end
    end
  endtask

  initial begin
    do_reset();
    test_reset();
    do_reset();
    test_single_frame();
    do_reset();
    test_back_to_back();
    do_reset();
    test_stall();
    do_reset();
    test_hold_pattern();
    do_reset();
    test_reset_mid_frame();
    do_reset();
    test_last_blocks();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/qpsk_mapper.md
QPSK_MAPPER -- requirements
Module: qpsk_mapper

Interface
REQ-001 SHALL have parameter AMP, default 1448, signed 12-bit symbol amplitude magnitude (legal range 1..2047).
REQ-002 SHALL have parameter PREAMBLE_LEN, default 16, number of preamble symbols emitted per frame (legal range 1..255).
REQ-003 clk  input  1  clock; all logic on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 i_data  input  8  payload byte, sent MSB dibit first.
REQ-006 i_valid  input  1  i_data/i_last valid.
REQ-007 i_last  input  1  byte is the last byte of the frame; sampled with the byte.
REQ-008 o_ready  output  1  byte accepted on a cycle where i_valid && o_ready.
REQ-009 o_I  output  12  signed in-phase symbol, registered.
REQ-010 o_Q  output  12  signed quadrature symbol, registered.
REQ-011 o_valid  output  1  o_I/o_Q hold a symbol.
REQ-012 i_out_ready  input  1  downstream (sample-hold stage ready-for-input); symbol transfers on a cycle where o_valid && i_out_ready.
REQ-013 o_busy  output  1  high whenever state != IDLE.

Function
REQ-014 SHALL implement FSM states IDLE, PREAMBLE, DATA.
REQ-015 IDLE: o_ready=0; i_valid=1 -> PREAMBLE next cycle; no byte consumed.
REQ-016 PREAMBLE: emit PREAMBLE_LEN symbols, symbol k (k=0..PREAMBLE_LEN-1) = dibit 00 for even k, 11 for odd k; after the last one loads into the output register -> DATA.
REQ-017 DATA: hold one byte register plus 2-bit dibit index and a stored last flag; dibits emitted bits[7:6],[5:4],[3:2],[1:0].
REQ-018 Gray map: I = +AMP if b1=0 else -AMP; Q = +AMP if b0=0 else -AMP; exact two's-complement 12-bit values, no rounding.
REQ-019 Output register advances (advance = !o_valid || i_out_ready) only when a next symbol is available; else o_valid drops to 0 on the transfer cycle.
REQ-020 While o_valid=1 and i_out_ready=0, o_I, o_Q, o_valid SHALL be stable; no symbol dropped or duplicated.
REQ-021 o_ready (combinational) = DATA && (byte register empty || (index==3 && advance && !stored_last)).
REQ-022 Back-to-back bytes with i_out_ready=1 SHALL give symbols on consecutive cycles, no bubble.
REQ-023 When dibit index 3 of a byte with stored_last=1 loads into the output register -> IDLE next cycle; no further byte accepted for that frame.
REQ-024 Symbol order across a frame: all preamble symbols, then payload dibits in byte order; o_valid gaps allowed only when upstream i_valid is low in DATA or downstream stalls.
REQ-025 A final symbol still in the output register when the FSM enters IDLE SHALL remain valid until transferred.
REQ-026 Latency: i_valid first high in IDLE at cycle N -> first preamble symbol o_valid=1 at N+2.

Reset
REQ-027 rst SHALL force: state IDLE, o_valid=0, o_I=0, o_Q=0, o_busy=0, o_ready=0, byte register empty, counters 0.
REQ-028 rst asserted mid-frame SHALL discard partial byte, pending symbol and preamble progress; next frame restarts with full preamble.
REQ-029 rst has priority over every other input in the same cycle.

Verification
REQ-030 PREAMBLE_LEN=4, AMP=1448, i_out_ready=1, single byte 0x1B last=1 -> (I,Q) sequence 0x5A8/0x5A8, 0xA58/0xA58, 0x5A8/0x5A8, 0xA58/0xA58, then 0x5A8/0x5A8, 0x5A8/0xA58, 0xA58/0x5A8, 0xA58/0xA58; then o_valid=0, o_busy=0.
REQ-031 Two-byte frame 0xFF,0x00 (last on second), i_out_ready=1, i_valid always high -> 8 payload symbols on 8 consecutive cycles: four (0xA58,0xA58) then four (0x5A8,0x5A8).
REQ-032 i_out_ready low 5 cycles while o_valid=1 -> o_I/o_Q unchanged for all 5 cycles; full symbol sequence intact afterwards.
REQ-033 i_out_ready high 1 cycle in every 8 (downstream hold pattern) -> exactly one symbol transferred per 8 cycles, order per REQ-030.
REQ-034 rst pulsed for 1 cycle during 2nd payload dibit -> o_valid=0 next cycle; new frame yields full PREAMBLE_LEN preamble before payload.
REQ-035 i_valid high with i_last=1 on first byte, second byte presented immediately -> second byte not accepted (o_ready=0) until next frame's preamble completes.
